// File: rtl/ospi_xfer_sequencer.sv
// Octal-SPI target transaction sequencer: one header-led transaction per ncs-low frame,
// moving bytes between the octal bus and the 2^ADDR_W x 8 transfer buffer RAM.
//
// state | meaning
// IDLE  | waiting for ncs low; the first byte of a frame is the opcode
// HDR   | collecting size and the three address bytes
// DUMMY | read turnaround; the last dummy cycle issues the first RAM read
// WDATA | bus bytes are written into the RAM
// RDATA | RAM bytes are driven back onto the bus
// DONE  | transfer complete; further bytes ignored until ncs high
// SKIP  | unknown opcode; bytes ignored until ncs high
module ospi_xfer_sequencer #(
    parameter int          ADDR_W       = 8,
    parameter int          DUMMY_CYCLES = 2,
    parameter logic [7:0]  CMD_WRITE    = 8'hA0,
    parameter logic [7:0]  CMD_READ     = 8'h20
) (
    input  logic              clkin,
    input  logic              reset_n,
    input  logic              ncs,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              data_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic [7:0]        last_cmd,
    output logic              xfer_done,
    output logic              xfer_err
);

    typedef enum logic [2:0] {
        IDLE, HDR, DUMMY, WDATA, RDATA, DONE, SKIP
    } state_t;

    localparam logic [3:0] DUMMY_LOAD = 4'(DUMMY_CYCLES - 1);

    state_t            state;
    logic [7:0]        cmd;
    logic [7:0]        size;
    logic [7:0]        addr2;
    logic [7:0]        addr1;
    logic [2:0]        hdr_cnt;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        remain;
    logic [3:0]        dcnt;
    logic              oe_q;
    logic [23:0]       hdr_addr;

    assign hdr_addr = {addr2, addr1, data_i};

    // Output enable releases the bus the moment the host deselects, not a cycle later.
    assign data_oe = oe_q & ~ncs;
    assign data_o  = data_oe ? ram_rdata : 8'h00;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd       <= 8'h00;
            size      <= 8'h00;
            addr2     <= 8'h00;
            addr1     <= 8'h00;
            hdr_cnt   <= 3'd0;
            ptr       <= '0;
            remain    <= 9'd0;
            dcnt      <= 4'd0;
            oe_q      <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'h00;
            ram_re    <= 1'b0;
            busy      <= 1'b0;
            last_cmd  <= 8'h00;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (!ncs) begin
                        cmd      <= data_i;
                        last_cmd <= data_i;
                        busy     <= 1'b1;
                        hdr_cnt  <= 3'd1;
                        state    <= HDR;
                    end
                end

                HDR: begin
                    if (ncs) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        oe_q     <= 1'b0;
                        xfer_err <= 1'b1;
                    end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            3'd1: size  <= data_i;
                            3'd2: addr2 <= data_i;
                            3'd3: addr1 <= data_i;
                            default: begin
                                ptr    <= ADDR_W'(hdr_addr);
                                remain <= {1'b0, size} + 9'd1;
                                dcnt   <= DUMMY_LOAD;
                                if (cmd == CMD_WRITE) begin
                                    state <= WDATA;
                                end else if (cmd == CMD_READ) begin
                                    state <= DUMMY;
                                end else begin
                                    xfer_err <= 1'b1;
                                    state    <= SKIP;
                                end
                            end
                        endcase
                    end
                end

                WDATA: begin
                    if (ncs) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        oe_q     <= 1'b0;
                        xfer_err <= 1'b1;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_addr  <= ptr;
                        ram_wdata <= data_i;
                        ptr       <= ptr + ADDR_W'(1);
                        remain    <= remain - 9'd1;
                        if (remain == 9'd1) begin
                            xfer_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DUMMY: begin
                    if (ncs) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        oe_q     <= 1'b0;
                        xfer_err <= 1'b1;
                    end else if (dcnt == 4'd0) begin
                        ram_re   <= 1'b1;
                        ram_addr <= ptr;
                        ptr      <= ptr + ADDR_W'(1);
                        state    <= RDATA;
                    end else begin
                        dcnt <= dcnt - 4'd1;
                    end
                end

                RDATA: begin
                    // remain==0 is the cycle after the last byte was presented.
                    if (remain == 9'd0) begin
                        oe_q      <= 1'b0;
                        xfer_done <= 1'b1;
                        if (ncs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DONE;
                        end
                    end else if (ncs) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        oe_q     <= 1'b0;
                        xfer_err <= 1'b1;
                    end else begin
                        oe_q   <= 1'b1;
                        remain <= remain - 9'd1;
                        if (remain != 9'd1) begin
                            ram_re   <= 1'b1;
                            ram_addr <= ptr;
                            ptr      <= ptr + ADDR_W'(1);
                        end
                    end
                end

                DONE, SKIP: begin
                    if (ncs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    oe_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ospi_xfer_sequencer.sv
// Bench for ospi_xfer_sequencer: directed frames, a frame-level expectation model checked
// every cycle, and literal per-frame expectations.
module tb_ospi_xfer_sequencer;

    localparam int DUMMY = 2;
    localparam int NC    = 4096;

    typedef logic [7:0] bq_t[$];

    logic       clkin   = 1'b0;
    logic       reset_n = 1'b0;
    logic       ncs     = 1'b1;
    logic [7:0] data_i  = 8'h00;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic       ram_re;
    logic [7:0] ram_rdata;
    logic       busy;
    logic [7:0] last_cmd;
    logic       xfer_done;
    logic       xfer_err;

    ospi_xfer_sequencer #(
        .ADDR_W(8), .DUMMY_CYCLES(DUMMY), .CMD_WRITE(8'hA0), .CMD_READ(8'h20)
    ) dut (
        .clkin(clkin), .reset_n(reset_n), .ncs(ncs), .data_i(data_i),
        .data_o(data_o), .data_oe(data_oe), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_rdata(ram_rdata), .busy(busy),
        .last_cmd(last_cmd), .xfer_done(xfer_done), .xfer_err(xfer_err)
    );

    always #5 clkin = ~clkin;

    // Buffer RAM attached to the DUT.
    logic [7:0] ram [256];
    always @(posedge clkin) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    // Expected outputs indexed by the clock edge that produces them.
    bit       e_we   [NC];
    bit       e_re   [NC];
    bit [7:0] e_addr [NC];
    bit [7:0] e_wd   [NC];
    bit       e_oe   [NC];
    bit [7:0] e_do   [NC];
    bit       e_done [NC];
    bit       e_err  [NC];
    bit       e_busy [NC];
    bit       e_start[NC];
    bit [7:0] e_cmd  [NC];
    bit [7:0] ref_mem[256];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: bytes b[0..L-1] are sampled with ncs low from edge F, ncs high at edge F+L.
    task automatic model_frame(input int f, input bq_t b);
        int l;
        int s;
        bit [7:0] a;
        l = b.size();
        for (int i = 0; i < l; i++) e_busy[f+i] = 1'b1;
        e_start[f] = 1'b1;
        e_cmd[f]   = b[0];
        if (l < 5) begin
            e_err[f+l] = 1'b1;
            return;
        end
        s = int'(b[1]);
        a = b[4];
        if (b[0] == 8'hA0) begin
            for (int j = 0; j <= s && 5 + j < l; j++) begin
                e_we[f+5+j]   = 1'b1;
                e_addr[f+5+j] = 8'(a + j);
                e_wd[f+5+j]   = b[5+j];
                ref_mem[8'(a + j)] = b[5+j];
            end
            if (l >= s + 6) e_done[f+5+s] = 1'b1;
            else            e_err[f+l]    = 1'b1;
        end else if (b[0] == 8'h20) begin
            for (int j = 0; j <= s; j++) begin
                if (4 + DUMMY + j < l) begin
                    e_re[f+4+DUMMY+j]   = 1'b1;
                    e_addr[f+4+DUMMY+j] = 8'(a + j);
                end
                if (5 + DUMMY + j < l) begin
                    e_oe[f+5+DUMMY+j] = 1'b1;
                    e_do[f+5+DUMMY+j] = ref_mem[8'(a + j)];
                end
            end
            if (l >= 6 + DUMMY + s) e_done[f+6+DUMMY+s] = 1'b1;
            else                    e_err[f+l]          = 1'b1;
        end else begin
            e_err[f+4] = 1'b1;
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin : cmp
        int e;
        bit exp_oe;
        bit [7:0] model_lc;
        model_lc = 8'h00;
        forever begin
            @(negedge clkin);
            if (!reset_n) begin
                model_lc = 8'h00;
            end else if (chk_en && cyc >= 1 && cyc <= NC) begin
                e = cyc - 1;
                if (e_start[e]) model_lc = e_cmd[e];
                exp_oe = e_oe[e] && !ncs;
                chk("ram_we", 32'(ram_we), 32'(e_we[e]));
                chk("ram_re", 32'(ram_re), 32'(e_re[e]));
                if (e_we[e]) begin
                    chk("ram_addr_wr", 32'(ram_addr), 32'(e_addr[e]));
                    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[e]));
                end
                if (e_re[e]) chk("ram_addr_rd", 32'(ram_addr), 32'(e_addr[e]));
                chk("data_oe", 32'(data_oe), 32'(exp_oe));
                chk("data_o", 32'(data_o), exp_oe ? 32'(e_do[e]) : 32'd0);
                chk("xfer_done", 32'(xfer_done), 32'(e_done[e]));
                chk("xfer_err", 32'(xfer_err), 32'(e_err[e]));
                chk("busy", 32'(busy), 32'(e_busy[e]));
                chk("last_cmd", 32'(last_cmd), 32'(model_lc));
            end
        end
    end

    // Running totals used for the literal per-frame expectations.
    int n_we = 0, n_re = 0, n_done = 0, n_err = 0, n_oe = 0;
    logic [7:0] oe_log [2048];
    initial begin : mon
        forever begin
            @(negedge clkin);
            if (ram_we)    n_we++;
            if (ram_re)    n_re++;
            if (xfer_done) n_done++;
            if (xfer_err)  n_err++;
            if (data_oe && n_oe < 2048) begin
                oe_log[n_oe] = data_o;
                n_oe++;
            end
        end
    end

    int s_we, s_re, s_done, s_err, s_oe;

    task automatic snap();
        s_we = n_we; s_re = n_re; s_done = n_done; s_err = n_err; s_oe = n_oe;
    endtask

    task automatic chk_counts(input string nm, input int we, input int done, input int err);
        chk({nm, "_we_count"}, 32'(n_we - s_we), 32'(we));
        chk({nm, "_done_count"}, 32'(n_done - s_done), 32'(done));
        chk({nm, "_err_count"}, 32'(n_err - s_err), 32'(err));
    endtask

    task automatic chk_rd(input string nm, input bq_t exp);
        chk({nm, "_oe_cycles"}, 32'(n_oe - s_oe), 32'(exp.size()));
        for (int i = 0; i < exp.size() && s_oe + i < n_oe; i++)
            chk({nm, "_data"}, 32'(oe_log[s_oe+i]), 32'(exp[i]));
    endtask

    task automatic run_frame(input bq_t b, input int gap);
        model_frame(cyc, b);
        for (int i = 0; i < b.size(); i++) begin
            ncs    = 1'b0;
            data_i = b[i];
            @(posedge clkin); #1;
        end
        ncs    = 1'b1;
        data_i = 8'h5A;
        repeat (gap) begin
            @(posedge clkin); #1;
        end
    endtask

    function automatic bq_t rd_frame(input logic [7:0] s, input logic [7:0] a, input int pad);
        bq_t q;
        q = {8'h20, s, 8'h00, 8'h00, a};
        for (int i = 0; i < pad; i++) q.push_back(8'h00);
        return q;
    endfunction

    initial begin : drv
        bq_t q;
        int t;

        #3;
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_re", 32'(ram_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_cmd", 32'(last_cmd), 32'd0);
        chk("rst_xfer_done", 32'(xfer_done), 32'd0);
        chk("rst_xfer_err", 32'(xfer_err), 32'd0);
        repeat (2) @(posedge clkin);
        #2 reset_n = 1'b1;
        @(posedge clkin); #1;
        chk_en = 1'b1;

        // Basic write of four bytes at 0x10.
        snap();
        run_frame({8'hA0, 8'h03, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44}, 2);
        chk_counts("wr", 4, 1, 0);
        chk("wr_ram10", 32'(ram[8'h10]), 32'h11);
        chk("wr_ram13", 32'(ram[8'h13]), 32'h44);

        // Read back.
        snap();
        run_frame(rd_frame(8'h03, 8'h10, 7), 2);
        chk_rd("rd", {8'h11, 8'h22, 8'h33, 8'h44});
        chk_counts("rd", 0, 1, 0);
        chk("rd_last_cmd", 32'(last_cmd), 32'h20);

        // Full-size write with address wrap and one surplus byte.
        q = {8'hA0, 8'hFF, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        q.push_back(8'hEE);
        snap();
        run_frame(q, 2);
        chk_counts("wrap", 256, 1, 0);
        chk("wrap_ram7f", 32'(ram[8'h7F]), 32'hFF);
        chk("wrap_ram80", 32'(ram[8'h80]), 32'h00);

        // Read across the top of the buffer.
        snap();
        run_frame(rd_frame(8'h03, 8'hFE, 7), 2);
        chk_rd("rdwrap", {8'h7E, 8'h7F, 8'h80, 8'h81});

        // Aborted write, immediately followed by a read of what landed.
        snap();
        run_frame({8'hA0, 8'h07, 8'h00, 8'h00, 8'h40, 8'hD0, 8'hD1, 8'hD2}, 1);
        run_frame(rd_frame(8'h02, 8'h40, 7), 2);
        chk_counts("abort", 3, 1, 1);
        chk_rd("abort", {8'hD0, 8'hD1, 8'hD2});

        // Unknown opcode.
        snap();
        run_frame({8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h88}, 2);
        chk_counts("unk", 0, 0, 1);
        chk("unk_re_count", 32'(n_re - s_re), 32'd0);
        chk("unk_oe_count", 32'(n_oe - s_oe), 32'd0);
        chk("unk_last_cmd", 32'(last_cmd), 32'h55);

        // Frame cut short inside the header.
        snap();
        run_frame({8'hA0, 8'h01}, 2);
        chk_counts("hdrabort", 0, 0, 1);

        // Single-byte read.
        snap();
        run_frame(rd_frame(8'h00, 8'h12, 5), 2);
        chk_rd("rd1", {8'h92});
        chk_counts("rd1", 0, 1, 0);

        // Read cut short after one presented byte.
        snap();
        run_frame(rd_frame(8'h03, 8'h10, 4), 2);
        chk_rd("rdabort", {8'h90});
        chk_counts("rdabort", 0, 0, 1);

        // Reset asserted while read data is on the bus.
        chk_en = 1'b0;
        q = rd_frame(8'h03, 8'h10, 0);
        for (int i = 0; i < q.size(); i++) begin
            ncs    = 1'b0;
            data_i = q[i];
            @(posedge clkin); #1;
        end
        t = 0;
        while (!data_oe && t < 20) begin
            @(posedge clkin); #1;
            t++;
        end
        chk("rstmid_oe_before", 32'(data_oe), 32'd1);
        chk("rstmid_re_before", 32'(ram_re), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_data_oe", 32'(data_oe), 32'd0);
        chk("rstmid_ram_re", 32'(ram_re), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        ncs = 1'b1;
        @(posedge clkin); #1;
        @(posedge clkin); #2;
        reset_n = 1'b1;
        @(posedge clkin); #1;
        chk("rstmid_last_cmd", 32'(last_cmd), 32'd0);
        chk("rstmid_busy_after", 32'(busy), 32'd0);
        chk_en = 1'b1;

        snap();
        run_frame(rd_frame(8'h03, 8'h10, 7), 2);
        chk_rd("recover", {8'h90, 8'h91, 8'h92, 8'h93});
        chk_counts("recover", 0, 1, 0);

        repeat (2) @(posedge clkin);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
